// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: MDU operation encoding shared with the EX stage
package mult_div_unit_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MFHI  = 3'b100,
    OP_MFLO  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } MduOp;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency multiply/divide unit owning HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  MduOp        op,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic        busy,
  output logic [31:0] result
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [63:0] smul, umul, sdiv, udiv, res;
  logic [31:0] sq, sr;
  // Result is computed at launch and parked until the latency expires.
  always_comb begin
    smul = {{32{rsData[31]}}, rsData} * {{32{rtData[31]}}, rtData};
    umul = {32'b0, rsData} * {32'b0, rtData};
    sq   = 32'($signed(rsData) / $signed(rtData));
    sr   = 32'($signed(rsData) % $signed(rtData));
    sdiv = rtData == 32'd0 ? {rsData, 32'hFFFF_FFFF} :
           (rsData == 32'h8000_0000 && rtData == 32'hFFFF_FFFF) ? {32'd0, 32'h8000_0000} :
           {sr, sq};
    udiv = rtData == 32'd0 ? {rsData, 32'hFFFF_FFFF} : {rsData % rtData, rsData / rtData};
    res  = op == OP_MULT ? smul : op == OP_MULTU ? umul : op == OP_DIV ? sdiv : udiv;
  end
  // Counter-driven sequencing: nonzero count means an operation is in flight.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    if (cnt_q != 5'd0) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start && !op[2]) begin
      pend_hi_d = res[63:32];
      pend_lo_d = res[31:0];
      cnt_d     = op[1] ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
    end else if (enable && op[2] && op[1]) begin
      if (op[0]) lo_d = rsData;
      else hi_d = rsData;
    end
    busy_d = cnt_d != 5'd0;
  end
  // State registers with synchronous reset that also aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end
  assign busy   = busy_q;
  assign result = op == OP_MFHI ? hi_q : op == OP_MFLO ? lo_q : 32'd0;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit (MDU) that owns the HI/LO registers. It sits in the EX stage and answers the MDU request fields of EXSignal: mduOp, mduStart and mduEnable. It accepts MULT/MULTU/DIV/DIVU and runs them for a fixed latency. It services MFHI/MFLO/MTHI/MTLO and raises busy so the hazard logic stalls EX.

Parameters:
MUL_CYCLES, 5, cycles busy stays high for MULT/MULTU (range 1..31)
DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (range 1..31)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  EXSignal.mduStart; launches a MULT/MULTU/DIV/DIVU
enable  in  1  EXSignal.mduEnable; qualifies MFHI/MFLO/MTHI/MTLO
op  in  3  EXSignal.mduOp, MduOp encoding
rsData  in  32  operand A (forwarded rs)
rtData  in  32  operand B (forwarded rt)
busy  out  1  operation in flight; EX stalls any start/enable while high
result  out  32  HI or LO value for MFHI/MFLO (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; state clears on the first rising edge of clk with reset high.
- Reset state: HI=0, LO=0, counter=0, busy=0, pending HI/LO=0. result follows op and HI/LO, so it reads 0 for MFHI/MFLO after reset.
- op encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- States: IDLE (counter==0) and RUN (counter!=0). busy = (counter!=0), driven from a register with no combinational path from inputs.
- IDLE with start=1 and op in 000..011:
  - compute the 64-bit result from rsData/rtData;
  - store it in pending HI/LO;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - enter RUN.
- RUN: counter decrements each cycle. On the edge where counter goes 1->0, HI/LO take the pending values and busy drops. busy is therefore high for exactly N cycles after the start edge. HI/LO are unchanged during RUN.
- start or enable while busy=1: ignored, no state change (EX must hold the instruction). start with op>=100, or enable with op<100: ignored.
- MTHI/MTLO (enable=1, IDLE): HI or LO <= rsData on the next edge.
- MFHI/MFLO: result = HI or LO combinationally whenever op is 100/101. For any other op, result = 0.
- MULT: signed 32x32->64; HI=upper word, LO=lower word. MULTU: unsigned.
- DIV: quotient truncates toward zero, to LO; remainder takes the sign of the dividend, to HI. DIVU: unsigned.
- Divide by zero (rtData=0), both signed and unsigned: LO=0xFFFFFFFF, HI=rsData.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- reset during RUN: aborts the operation; pending result is discarded; all state returns to reset values on that edge.
- start and reset in the same cycle: reset wins.

Decomposition:
- defs gets `typedef enum logic[2:0] MduOp` with the encoding above; EXSignal.mduOp changes to MduOp.
- Latency constants stay as module parameters.
- No sub-module: the datapath is one multiplier and one divider expression plus a 5-bit counter, all inline.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFE.
- MULTU rs=0xFFFFFFFF rt=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; MFLO issued during busy produces result only after EX is released (stall held).
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7 rt=0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI rs=0x12345678 then MFHI -> result=0x12345678 the cycle after. MTLO while busy -> LO unchanged until busy drops and the MTLO is reissued.
- Start DIV, assert reset at cycle 4 -> busy=0 and HI=LO=0 after that edge; the pending quotient never appears.
- Back-to-back: MULT, then DIVU presented while busy -> DIVU ignored until busy=0; when reissued it completes DIV_CYCLES later with the correct values.
